// File: rtl/fifo_drain_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_packer
// Description : Read-side consumer for an 8-bit FIFO. Pops words with a fixed
//               one-cycle read latency and packs RATIO consecutive words into
//               one wide word. The first popped word lands in the low slice.
//               Packed words leave on a valid/ready stream. A flush request
//               emits any partial word with its unused slots zeroed.
// Ports       : CLOCK        - rising-edge clock shared with the FIFO
//               RESET_N      - synchronous active-low reset
//               FIFO_DATA    - FIFO DATA_OUT, valid one cycle after a pop
//               FIFO_EMPTY_N - FIFO F_EMPTY_N, 1 = FIFO holds data
//               FIFO_READ    - FIFO READ, pop request
//               FLUSH        - single-cycle request to emit a partial word
//               OUT_DATA     - packed word
//               OUT_BYTES    - number of valid FIFO words in OUT_DATA
//               OUT_VALID    - OUT_DATA/OUT_BYTES valid
//               OUT_READY    - downstream accepts on OUT_VALID & OUT_READY
//               BUSY         - any word or request still in progress
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_packer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                     CLOCK,
    input  logic                     RESET_N,
    input  logic [WIDTH-1:0]         FIFO_DATA,
    input  logic                     FIFO_EMPTY_N,
    output logic                     FIFO_READ,
    input  logic                     FLUSH,
    output logic [WIDTH*RATIO-1:0]   OUT_DATA,
    output logic [$clog2(RATIO):0]   OUT_BYTES,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic                     BUSY
);

    // The slot counter shares the OUT_BYTES width; it must be able to hold
    // RATIO to mark a completed word that is parked in the assembly register.
    localparam int                 BYTES_W   = $clog2(RATIO) + 1;
    localparam logic [BYTES_W-1:0] c_full    = BYTES_W'(RATIO);
    localparam logic [BYTES_W-1:0] c_last    = BYTES_W'(RATIO - 1);
    localparam logic [BYTES_W:0]   c_limit   = (BYTES_W + 1)'(RATIO);

    logic [BYTES_W-1:0]     r_cnt;
    logic                   r_inflight;
    logic                   r_flush_pend;
    logic [WIDTH*RATIO-1:0] r_asm;
    logic [WIDTH*RATIO-1:0] r_out_data;
    logic [BYTES_W-1:0]     r_out_bytes;
    logic                   r_out_valid;

    logic [BYTES_W:0]       w_fill;
    logic                   w_read;
    logic                   w_slot_free;
    logic [WIDTH*RATIO-1:0] w_asm_next;
    logic [WIDTH*RATIO-1:0] w_asm_masked;

    // Words already captured plus the one in flight must leave room for the
    // word this pop would bring in; a pending flush freezes the assembly.
    assign w_fill      = {1'b0, r_cnt} + {{BYTES_W{1'b0}}, r_inflight};
    assign w_read      = FIFO_EMPTY_N & ~r_flush_pend & (w_fill < c_limit);
    assign w_slot_free = ~r_out_valid | OUT_READY;

    // Assembly contents including the word arriving this cycle, so a word
    // completed by this capture can go straight to the output register.
    always_comb begin
        w_asm_next = r_asm;
        for (int i = 0; i < RATIO; i++) begin
            if (r_inflight && (r_cnt == BYTES_W'(i))) begin
                w_asm_next[i*WIDTH +: WIDTH] = FIFO_DATA;
            end
        end
    end

    // Partial words are zeroed above the last captured slot at output time,
    // so the assembly register never needs clearing between words.
    always_comb begin
        w_asm_masked = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (BYTES_W'(i) < r_cnt) begin
                w_asm_masked[i*WIDTH +: WIDTH] = r_asm[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_cnt        <= '0;
            r_inflight   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_asm        <= '0;
            r_out_data   <= '0;
            r_out_bytes  <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            r_inflight <= w_read;
            r_asm      <= w_asm_next;

            if (r_out_valid && OUT_READY) begin
                r_out_valid <= 1'b0;
            end

            if (r_inflight) begin
                if (r_cnt != c_last) begin
                    r_cnt <= r_cnt + BYTES_W'(1);
                end else if (w_slot_free) begin
                    r_out_data  <= w_asm_next;
                    r_out_bytes <= c_full;
                    r_out_valid <= 1'b1;
                    r_cnt       <= '0;
                end else begin
                    r_cnt <= c_full;
                end
            end else if (r_cnt == c_full) begin
                // Parked full word; a pending flush stays pending and is
                // resolved on a later cycle once the counter reads zero.
                if (w_slot_free) begin
                    r_out_data  <= r_asm;
                    r_out_bytes <= c_full;
                    r_out_valid <= 1'b1;
                    r_cnt       <= '0;
                end
            end else if (r_flush_pend && w_slot_free) begin
                if (r_cnt != '0) begin
                    r_out_data  <= w_asm_masked;
                    r_out_bytes <= r_cnt;
                    r_out_valid <= 1'b1;
                    r_cnt       <= '0;
                end
                r_flush_pend <= 1'b0;
            end

            // Set and clear are mutually exclusive: clearing requires the
            // flag already set, and further requests are ignored while set.
            if (FLUSH && !r_flush_pend) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    assign FIFO_READ = w_read;
    assign OUT_DATA  = r_out_data;
    assign OUT_BYTES = r_out_bytes;
    assign OUT_VALID = r_out_valid;
    assign BUSY      = (r_cnt != '0) | r_inflight | r_flush_pend | r_out_valid;

endmodule
`default_nettype wire
